// File: rtl/sram_stream_engine.sv
// Streams LEN words from a source region of a shared SRAM to a destination region, applying a
// per-word mode operation (copy / add constant / running sum / invert) at one word per cycle.
module sram_stream_engine #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 12,
   parameter int LEN_W    = 12,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dut_run,
   input  logic              dut_abort,
   input  logic [ADDR_W-1:0] cfg_src_base,
   input  logic [ADDR_W-1:0] cfg_dst_base,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [1:0]        cfg_mode,
   input  logic [DATA_W-1:0] cfg_k,
   output logic              dut_busy,
   output logic              done,
   output logic              aborted,
   output logic [LEN_W-1:0]  words_written,
   input  logic [DATA_W-1:0] sram_read_data,
   output logic [ADDR_W-1:0] sram_read_addr,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_write_addr,
   output logic [DATA_W-1:0] sram_write_data
);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

   state_t              state_q;
   logic [LEN_W-1:0]    rd_left_q;
   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [1:0]          mode_q;
   logic [DATA_W-1:0]   k_q;
   logic [DATA_W-1:0]   acc_q;
   logic                abort_seen_q;
   logic [READ_LAT-1:0] pipe_q;

   logic                pipe_out;
   logic [DATA_W-1:0]   sum;
   logic [DATA_W-1:0]   result;

   // Read data is valid exactly when the oldest pipe stage holds an issued read.
   assign pipe_out = pipe_q[READ_LAT-1];

   always_comb begin
      sum    = acc_q + sram_read_data;
      result = sram_read_data;
      unique case (mode_q)
         2'b00: result = sram_read_data;
         2'b01: result = sram_read_data + k_q;
         2'b10: result = sum;
         2'b11: result = ~sram_read_data;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= StIdle;
         rd_left_q       <= '0;
         wr_ptr_q        <= '0;
         mode_q          <= '0;
         k_q             <= '0;
         acc_q           <= '0;
         abort_seen_q    <= 1'b0;
         pipe_q          <= '0;
         dut_busy        <= 1'b0;
         done            <= 1'b0;
         aborted         <= 1'b0;
         words_written   <= '0;
         sram_read_addr  <= '0;
         sram_we         <= 1'b0;
         sram_write_addr <= '0;
         sram_write_data <= '0;
      end else begin
         done      <= 1'b0;
         sram_we   <= pipe_out;
         pipe_q[0] <= (state_q == StIssue);
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end

         if (pipe_out) begin
            sram_write_addr <= wr_ptr_q;
            sram_write_data <= result;
            wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
            words_written   <= words_written + LEN_W'(1);
            if (mode_q == 2'b10) begin
               acc_q <= sum;
            end
         end

         case (state_q)
            StIdle: begin
               if (dut_run) begin
                  sram_read_addr <= cfg_src_base;
                  wr_ptr_q       <= cfg_dst_base;
                  rd_left_q      <= cfg_len;
                  mode_q         <= cfg_mode;
                  k_q            <= cfg_k;
                  acc_q          <= '0;
                  abort_seen_q   <= 1'b0;
                  words_written  <= '0;
                  aborted        <= 1'b0;
                  if (cfg_len == '0) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q  <= StIssue;
                     dut_busy <= 1'b1;
                  end
               end
            end
            StIssue: begin
               if (rd_left_q == LEN_W'(1) || dut_abort) begin
                  state_q <= StDrain;
                  // An abort coinciding with the final read does not cut anything short.
                  abort_seen_q <= dut_abort && (rd_left_q != LEN_W'(1));
               end else begin
                  sram_read_addr <= sram_read_addr + ADDR_W'(1);
                  rd_left_q      <= rd_left_q - LEN_W'(1);
               end
            end
            StDrain: begin
               if (pipe_q == '0) begin
                  state_q  <= StDone;
                  done     <= 1'b1;
                  dut_busy <= 1'b0;
                  aborted  <= abort_seen_q;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_stream_engine.sv
// Scoreboard bench: a READ_LAT=1 and a READ_LAT=3 engine share one SRAM model; expected writes
// are queued at issue time and popped by a monitor whenever either engine asserts sram_we.
module tb_sram_stream_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        run1, run3, abort;
   logic [11:0] src, dst, len;
   logic [1:0]  mode;
   logic [15:0] k;

   logic        busy1, done1, ab1, we1, busy3, done3, ab3, we3;
   logic [11:0] ww1, ra1, wa1, ww3, ra3, wa3;
   logic [15:0] rd1, wd1, rd3, wd3;

   logic        pl_en;
   logic [11:0] pl_addr;
   logic [15:0] pl_data;
   logic [15:0] mem [0:4095];
   logic [15:0] p3 [0:1];

   int cyc = 0;
   int nchk = 0;
   int nerr = 0;
   int ndone1 = 0;

   typedef struct {
      int          id;
      logic [11:0] addr;
      logic [15:0] data;
      int          cyc;
   } wr_t;
   wr_t sb[$];

   always #5 clk = ~clk;

   sram_stream_engine #(.DATA_W(16), .ADDR_W(12), .LEN_W(12), .READ_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .dut_run(run1), .dut_abort(abort),
      .cfg_src_base(src), .cfg_dst_base(dst), .cfg_len(len), .cfg_mode(mode), .cfg_k(k),
      .dut_busy(busy1), .done(done1), .aborted(ab1), .words_written(ww1),
      .sram_read_data(rd1), .sram_read_addr(ra1), .sram_we(we1),
      .sram_write_addr(wa1), .sram_write_data(wd1)
   );

   sram_stream_engine #(.DATA_W(16), .ADDR_W(12), .LEN_W(12), .READ_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .dut_run(run3), .dut_abort(abort),
      .cfg_src_base(src), .cfg_dst_base(dst), .cfg_len(len), .cfg_mode(mode), .cfg_k(k),
      .dut_busy(busy3), .done(done3), .aborted(ab3), .words_written(ww3),
      .sram_read_data(rd3), .sram_read_addr(ra3), .sram_we(we3),
      .sram_write_addr(wa3), .sram_write_data(wd3)
   );

   // SRAM model: 1-cycle read path for dut1, 3-cycle path for dut3
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rd1   <= mem[ra1];
      p3[0] <= mem[ra3];
      p3[1] <= p3[0];
      rd3   <= p3[1];
      if (pl_en) mem[pl_addr] <= pl_data;
      if (we1) mem[wa1] <= wd1;
      if (we3) mem[wa3] <= wd3;
   end

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_write(input int id, input logic [11:0] a, input logic [15:0] d);
      wr_t e;
      nchk++;
      if (sb.size() == 0) begin
         nerr++;
         $display("FAIL unexpected_write dut%0d: addr 0x%0h data 0x%0h cycle %0d", id, a, d, cyc);
      end else begin
         e = sb.pop_front();
         if (e.id != id || e.addr != a || e.data != d || e.cyc != cyc) begin
            nerr++;
            $display("FAIL write dut%0d: got addr 0x%0h data 0x%0h cyc %0d, expected dut%0d addr 0x%0h data 0x%0h cyc %0d",
                     id, a, d, cyc, e.id, e.addr, e.data, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (we1) check_write(1, wa1, wd1);
      if (we3) check_write(3, wa3, wd3);
      if (done1) ndone1++;
   end

   task automatic expect_wr(input int id, input logic [11:0] a, input logic [15:0] d, input int c);
      wr_t e;
      e.id = id; e.addr = a; e.data = d; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic poke(input logic [11:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // Returns c0 = cycle in which run is sampled; on return we are just inside cycle 1.
   task automatic start(input int id, input logic [11:0] s, input logic [11:0] d,
                        input logic [11:0] n, input logic [1:0] m, input logic [15:0] kk,
                        output int c0);
      @(negedge clk);
      src = s; dst = d; len = n; mode = m; k = kk;
      if (id == 1) run1 = 1'b1; else run3 = 1'b1;
      c0 = cyc;
      @(posedge clk);
      #1;
      run1 = 1'b0; run3 = 1'b0;
   endtask

   task automatic wait_done(input int id, input int exp_c, input string nm);
      int got;
      got = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((id == 1) ? done1 : done3) begin
            got = cyc;
            break;
         end
      end
      chk({nm, "_done_cycle"}, got, exp_c);
      chk({nm, "_busy_at_done"}, (id == 1) ? busy1 : busy3, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int c;
      int nd;
      reset = 1'b1; run1 = 1'b0; run3 = 1'b0; abort = 1'b0;
      src = '0; dst = '0; len = '0; mode = '0; k = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_we", we1, 0);
      chk("rst_ww", ww1, 0);
      chk("rst_ra3", ra3, 0);
      chk("rst_wd3", wd3, 0);
      reset = 1'b0;

      for (int i = 0; i < 4; i++) poke(12'h010 + 12'(i), 16'(i + 1));
      poke(12'h020, 16'hFFFF); poke(12'h021, 16'h0002); poke(12'h022, 16'h0003);
      poke(12'hFFE, 16'h1000); poke(12'hFFF, 16'h2000);
      poke(12'h000, 16'h3000); poke(12'h001, 16'h4000);
      poke(12'h040, 16'h00FF); poke(12'h041, 16'hA5A5);
      for (int i = 0; i < 10; i++) poke(12'h050 + 12'(i), 16'h0100 + 16'(i));
      poke(12'h070, 16'hBEEF); poke(12'h071, 16'hCAFE);
      poke(12'h060, 16'h1234); poke(12'h061, 16'h5678);

      // Copy
      start(1, 12'h010, 12'h100, 12'd4, 2'b00, 16'h0, c);
      for (int j = 0; j < 4; j++) expect_wr(1, 12'h100 + 12'(j), 16'(j + 1), c + 3 + j);
      @(negedge clk);
      chk("copy_busy_cycle1", busy1, 1);
      wait_done(1, c + 7, "copy");
      chk("copy_ww", ww1, 4);
      chk("copy_aborted", ab1, 0);
      @(negedge clk);
      chk("copy_done_one_cycle", done1, 0);

      // Running sum with wrap
      start(1, 12'h020, 12'h200, 12'd3, 2'b10, 16'h0, c);
      expect_wr(1, 12'h200, 16'hFFFF, c + 3);
      expect_wr(1, 12'h201, 16'h0001, c + 4);
      expect_wr(1, 12'h202, 16'h0004, c + 5);
      wait_done(1, c + 6, "rsum");
      chk("rsum_ww", ww1, 3);

      // Add constant across the address wrap
      start(1, 12'hFFE, 12'h300, 12'd4, 2'b01, 16'h0010, c);
      expect_wr(1, 12'h300, 16'h1010, c + 3);
      expect_wr(1, 12'h301, 16'h2010, c + 4);
      expect_wr(1, 12'h302, 16'h3010, c + 5);
      expect_wr(1, 12'h303, 16'h4010, c + 6);
      wait_done(1, c + 7, "add");

      // Invert
      start(1, 12'h040, 12'h380, 12'd2, 2'b11, 16'h0, c);
      expect_wr(1, 12'h380, 16'hFF00, c + 3);
      expect_wr(1, 12'h381, 16'h5A5A, c + 4);
      wait_done(1, c + 5, "inv");

      // Abort in the cycle of the 3rd read
      start(1, 12'h050, 12'h400, 12'd10, 2'b00, 16'h0, c);
      for (int j = 0; j < 3; j++) expect_wr(1, 12'h400 + 12'(j), 16'h0100 + 16'(j), c + 3 + j);
      repeat (3) @(negedge clk);
      chk("abort_ra_c3", ra1, 12'h052);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_ra_c4", ra1, 12'h052);
      @(negedge clk);
      chk("abort_ra_c5", ra1, 12'h052);
      wait_done(1, c + 6, "abort");
      chk("abort_aborted", ab1, 1);
      chk("abort_ww", ww1, 3);
      @(negedge clk);
      chk("abort_aborted_held", ab1, 1);

      // len = 0
      start(1, 12'h010, 12'h700, 12'd0, 2'b00, 16'h0, c);
      wait_done(1, c + 1, "len0");
      chk("len0_aborted_cleared", ab1, 0);
      chk("len0_ww", ww1, 0);
      @(negedge clk);
      chk("len0_busy_after", busy1, 0);

      // Reset during the 5th read; only the first two writes get out
      start(1, 12'h070, 12'h600, 12'd10, 2'b00, 16'h0, c);
      expect_wr(1, 12'h600, 16'hBEEF, c + 3);
      expect_wr(1, 12'h601, 16'hCAFE, c + 4);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2;
      nd = ndone1;
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy1, 0);
      chk("midrst_we", we1, 0);
      chk("midrst_ra", ra1, 0);
      chk("midrst_wa", wa1, 0);
      chk("midrst_wd", wd1, 0);
      chk("midrst_ww", ww1, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_no_done", ndone1, nd);
      chk("midrst_busy_after", busy1, 0);

      // READ_LAT = 3 rerun
      start(3, 12'h060, 12'h500, 12'd2, 2'b00, 16'h0, c);
      expect_wr(3, 12'h500, 16'h1234, c + 5);
      expect_wr(3, 12'h501, 16'h5678, c + 6);
      @(negedge clk);
      chk("lat3_busy_cycle1", busy3, 1);
      wait_done(3, c + 7, "lat3");
      chk("lat3_ww", ww3, 2);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
